// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns the MEM-stage access into one request/grant/response
// bus transaction, formats store lanes and load results, and stalls the pipeline meanwhile.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store_data,
  output logic        mem_busy,
  output logic        mem_access_fault,
  output logic [31:0] mem_read_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;

  logic access_s;
  logic illegal_f3_s;
  logic misalign_s;
  logic fault_s;
  logic start_s;

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      3'b000:  w = {4{d[7:0]}};
      3'b001:  w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << lane;
      3'b001:  s = lane[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Access decode: legality, alignment and the combinational stall request
  always_comb begin
    access_s     = mem_load ^ mem_store;
    illegal_f3_s = 1'b0;
    misalign_s   = 1'b0;
    case (mem_funct3)
      3'b000, 3'b100: misalign_s = 1'b0;
      3'b001, 3'b101: misalign_s = mem_addr[0];
      3'b010:         misalign_s = |mem_addr[1:0];
      default:        illegal_f3_s = 1'b1;
    endcase
    fault_s = (mem_load & mem_store) |
              (access_s & (illegal_f3_s | misalign_s | (mem_store & mem_funct3[2])));
    start_s = access_s & ~fault_s;
    if (state_q == S_IDLE) begin
      mem_busy = start_s;
    end else begin
      mem_busy = (state_q == S_REQ) | (state_q == S_WAIT);
    end
    mem_access_fault = fault_s;
  end

  // Transaction FSM with registered bus outputs and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      funct3_q <= 3'd0;
      lane_q   <= 2'd0;
      rdata_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            state_q  <= S_REQ;
            req_q    <= 1'b1;
            we_q     <= mem_store;
            addr_q   <= {mem_addr[31:2], 2'b00};
            wdata_q  <= mem_store ? store_wdata(mem_funct3, mem_store_data) : 32'd0;
            wstrb_q  <= mem_store ? store_wstrb(mem_funct3, mem_addr[1:0]) : 4'd0;
            funct3_q <= mem_funct3;
            lane_q   <= mem_addr[1:0];
          end
        end
        S_REQ: begin
          if (dbus_gnt) begin
            req_q   <= 1'b0;
            state_q <= we_q ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dbus_rvalid) begin
            rdata_q <= load_format(funct3_q, lane_q, dbus_rdata);
            state_q <= S_DONE;
          end
        end
        // DONE ignores its inputs so the instruction leaving MEM now is not re-issued
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_read_data = rdata_q;
  assign dbus_req      = req_q;
  assign dbus_we       = we_q;
  assign dbus_addr     = addr_q;
  assign dbus_wdata    = wdata_q;
  assign dbus_wstrb    = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected bus transactions and load results are
// queued as each access is driven and compared against what the DUT actually issues.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_load, mem_store;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_store_data;
  logic        mem_busy, mem_access_fault;
  logic [31:0] mem_read_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  logic [31:0] exp_rd_q[$];
  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_load(mem_load), .mem_store(mem_store),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .mem_busy(mem_busy), .mem_access_fault(mem_access_fault), .mem_read_data(mem_read_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_wstrb(dbus_wstrb), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  // Drives one access and plays the bus slave; records every granted request in obs_q
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                            output int busy_n, output int req_n, output logic fault0,
                            output logic done_req, output logic [31:0] rd);
    int   waits;
    bit   waiting;
    bit   fin;
    txn_t t;
    busy_n = 0; req_n = 0; waits = 0; waiting = 1'b0; fin = 1'b0;
    fault0 = 1'b0; done_req = 1'b0; rd = 32'd0;
    mem_load = ld; mem_store = st; mem_funct3 = f3; mem_addr = a; mem_store_data = d;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) fault0 = mem_access_fault;
      if (!mem_busy) begin
        fin = 1'b1;
        done_req = dbus_req;
        rd = mem_read_data;
      end else begin
        busy_n++;
        if (dbus_req) begin
          if (req_n == gnt_dly) begin
            dbus_gnt = 1'b1;
            t.addr = dbus_addr; t.we = dbus_we; t.wdata = dbus_wdata; t.wstrb = dbus_wstrb;
            obs_q.push_back(t);
            waiting = !dbus_we;
          end
          req_n++;
        end else if (waiting) begin
          if (waits == rv_dly) begin
            dbus_rvalid = 1'b1;
            dbus_rdata = rdata;
            waiting = 1'b0;
          end
          waits++;
        end
      end
      @(posedge clk); #1;
      dbus_gnt = 1'b0;
      dbus_rvalid = 1'b0;
    end
    mem_load = 1'b0;
    mem_store = 1'b0;
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL access_timeout: busy never dropped within 40 cycles (addr %h)", a);
    end
  endtask

  task automatic pop_pair(output txn_t e, output txn_t o);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_load = 1'b0; mem_store = 1'b0; mem_funct3 = 3'd0; mem_addr = 32'd0;
    mem_store_data = 32'd0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, mem_read_data, mem_busy,
         mem_access_fault} !== 104'd0) begin
      n_err++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h wstrb=%b rd=%h busy=%b, want all 0",
               dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, mem_read_data, mem_busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_store_word();
    int busy_n, req_n; logic f0, dreq; logic [31:0] rd; txn_t e, o;
    exp_q.push_back('{addr: 32'h100, we: 1'b1, wdata: 32'hDEADBEEF, wstrb: 4'b1111});
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 32'd0, busy_n, req_n, f0, dreq, rd);
    pop_pair(e, o);
    n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL sw_txn: got %h want %h", o, e); end
    n_cmp++;
    if (req_n !== 2) begin n_err++; $display("FAIL sw_req_cycles: got %0d want 2", req_n); end
    n_cmp++;
    if (busy_n !== 3) begin n_err++; $display("FAIL sw_busy_cycles: got %0d want 3", busy_n); end
    n_cmp++;
    if (dreq !== 1'b0) begin n_err++; $display("FAIL sw_done_req: got %b want 0", dreq); end
  endtask

  task automatic test_store_lanes();
    int busy_n, req_n; logic f0, dreq; logic [31:0] rd; txn_t e, o;
    for (int l = 0; l < 4; l++) begin
      exp_q.push_back('{addr: 32'h100, we: 1'b1, wdata: 32'hA5A5A5A5, wstrb: 4'(1 << l)});
      run_access(1'b0, 1'b1, 3'b000, 32'h100 + 32'(l), 32'h000000A5, 0, 0, 32'd0,
                 busy_n, req_n, f0, dreq, rd);
      pop_pair(e, o);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sb_lane%0d: got %h want %h", l, o, e); end
    end
    for (int l = 0; l < 2; l++) begin
      exp_q.push_back('{addr: 32'h200, we: 1'b1, wdata: 32'h12341234,
                        wstrb: (l == 1) ? 4'b1100 : 4'b0011});
      run_access(1'b0, 1'b1, 3'b001, 32'h200 + 32'(2 * l), 32'hBEEF1234, 0, 0, 32'd0,
                 busy_n, req_n, f0, dreq, rd);
      pop_pair(e, o);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sh_half%0d: got %h want %h", l, o, e); end
    end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3_t[8]  = '{3'b000, 3'b100, 3'b001, 3'b000, 3'b101, 3'b001, 3'b001, 3'b010};
    logic [31:0] a_t[8]   = '{32'h102, 32'h102, 32'h102, 32'h101, 32'h100, 32'h100, 32'h102, 32'h104};
    logic [31:0] rd_t[8]  = '{32'h12F43456, 32'h12F43456, 32'h12F43456, 32'h12F43456,
                              32'h8001FFFF, 32'h8001FFFF, 32'h8001FFFF, 32'hCAFEBABE};
    logic [31:0] ex_t[8]  = '{32'hFFFFFFF4, 32'h000000F4, 32'h000012F4, 32'h00000034,
                              32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF8001, 32'hCAFEBABE};
    int busy_n, req_n; logic f0, dreq; logic [31:0] rd, er; txn_t e, o;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{addr: {a_t[i][31:2], 2'b00}, we: 1'b0, wdata: 32'd0, wstrb: 4'd0});
      exp_rd_q.push_back(ex_t[i]);
      run_access(1'b1, 1'b0, f3_t[i], a_t[i], 32'hFFFFFFFF, i % 3, i % 2, rd_t[i],
                 busy_n, req_n, f0, dreq, rd);
      pop_pair(e, o);
      er = exp_rd_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL load%0d_txn: got %h want %h", i, o, e); end
      n_cmp++;
      if (rd !== er) begin n_err++; $display("FAIL load%0d_data: got %h want %h", i, rd, er); end
      n_cmp++;
      if (busy_n !== 3 + (i % 3) + (i % 2)) begin
        n_err++;
        $display("FAIL load%0d_busy: got %0d want %0d", i, busy_n, 3 + (i % 3) + (i % 2));
      end
    end
  endtask

  task automatic test_faults();
    logic        ld_t[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        st_t[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3_t[6] = '{3'b010, 3'b001, 3'b011, 3'b110, 3'b100, 3'b010};
    logic [31:0] a_t[6]  = '{32'h101, 32'h003, 32'h000, 32'h000, 32'h000, 32'h000};
    int busy_n, req_n; logic f0, dreq; logic [31:0] rd;
    for (int i = 0; i < 6; i++) begin
      run_access(ld_t[i], st_t[i], f3_t[i], a_t[i], 32'h5A5A5A5A, 0, 0, 32'd0,
                 busy_n, req_n, f0, dreq, rd);
      n_cmp++;
      if ({f0, busy_n[7:0], req_n[7:0], 8'(obs_q.size())} !== {1'b1, 24'd0}) begin
        n_err++;
        $display("FAIL fault%0d: fault=%b busy=%0d req=%0d txns=%0d want fault=1 others 0",
                 i, f0, busy_n, req_n, obs_q.size());
        obs_q.delete();
      end
    end
  endtask

  task automatic test_reset_mid();
    mem_load = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h200;
    @(posedge clk); #1;
    dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b0;
    mem_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, mem_read_data, mem_busy} !== 103'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: req=%b we=%b addr=%h wdata=%h wstrb=%b rd=%h busy=%b, want all 0",
               dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, mem_read_data, mem_busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_read_data, dbus_req, mem_busy} !== 34'd0) begin
      n_err++;
      $display("FAIL midreset_stale_rvalid: rd=%h req=%b busy=%b want 0", mem_read_data, dbus_req, mem_busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int busy_a, req_a, busy_b, req_b; logic f0, dreq_a, dreq_b; logic [31:0] rd_a, rd_b, er;
    txn_t e, o;
    exp_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'd0, wstrb: 4'd0});
    exp_q.push_back('{addr: 32'h304, we: 1'b1, wdata: 32'h11223344, wstrb: 4'b1111});
    exp_rd_q.push_back(32'h55AA33CC);
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 0, 0, 32'h55AA33CC, busy_a, req_a, f0, dreq_a, rd_a);
    run_access(1'b0, 1'b1, 3'b010, 32'h304, 32'h11223344, 0, 0, 32'd0, busy_b, req_b, f0, dreq_b, rd_b);
    n_cmp++;
    if (obs_q.size() !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < 2; i++) begin
      pop_pair(e, o);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL b2b_txn%0d: got %h want %h", i, o, e); end
    end
    er = exp_rd_q.pop_front();
    n_cmp++;
    if ({rd_a, rd_b} !== {er, er}) begin
      n_err++;
      $display("FAIL b2b_read_data: load=%h after_store=%h want %h", rd_a, rd_b, er);
    end
    n_cmp++;
    if ({dreq_a, dreq_b, req_a[3:0], req_b[3:0], busy_a[3:0], busy_b[3:0]} !== {2'b00, 4'd1, 4'd1, 4'd3, 4'd2}) begin
      n_err++;
      $display("FAIL b2b_timing: done_req=%b%b req=%0d/%0d busy=%0d/%0d want 00 1/1 3/2",
               dreq_a, dreq_b, req_a, req_b, busy_a, busy_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_word();
    test_store_lanes();
    test_load_format();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the memory access of the instruction currently in MEM and runs it over a request/grant/response data bus. Byte, halfword and word stores have lane-aligned data and byte strobes. Load results are returned sign- or zero-extended as `mem_read_data`. While an access is outstanding, `mem_busy` holds the pipeline; it is used to drive the MEM/WB and upstream pipeline enables low.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_load`  in  1  instruction in MEM is a load.
- `mem_store`  in  1  instruction in MEM is a store.
- `mem_funct3`  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_addr`  in  32  effective byte address.
- `mem_store_data`  in  32  rs2 value, LSB-justified.
- `mem_busy`  out  1  stall request, combinational.
- `mem_access_fault`  out  1  misaligned or illegal access, combinational.
- `mem_read_data`  out  32  formatted load result, registered.
- `dbus_req`  out  1  bus request, registered.
- `dbus_we`  out  1  1 = write.
- `dbus_addr`  out  32  word address; bits [1:0] always 0.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_wstrb`  out  4  byte strobes; 0000 for reads.
- `dbus_gnt`  in  1  request accepted this cycle.
- `dbus_rvalid`  in  1  read data valid.
- `dbus_rdata`  in  32  read word.

## Operation
- Access is `mem_load` XOR `mem_store`.
  - Both `mem_load` and `mem_store` high is illegal: `mem_access_fault`=1 and no bus activity.
- `mem_access_fault`=1 when any of the following holds:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - `funct3` ∈ {011, 110, 111}.
  - Stores with `funct3`[2]=1.
- A faulting access never starts a bus transaction and never stalls.
- FSM states and transitions:
  - **IDLE**: a valid non-faulting access latches address, we, wdata, wstrb, `funct3` and `addr[1:0]`, then goes to REQ.
  - **REQ**: `dbus_req`=1 with all bus outputs stable. On `dbus_gnt`: a store goes to DONE; a load goes to WAIT.
  - **WAIT**: on `dbus_rvalid`, `mem_read_data` ← formatted `dbus_rdata`, then go to DONE.
  - **DONE**: lasts exactly one cycle, then returns to IDLE. DONE ignores its inputs; this prevents re-issuing the instruction that advances at this edge.
- `mem_busy` = (IDLE & valid non-faulting access) | REQ | WAIT.
- Store formatting:
  - SB: wdata = {4{d[7:0]}}, wstrb = 0001 << `addr[1:0]`.
  - SH: wdata = {2{d[15:0]}}, wstrb = 0011 << (2·`addr[1]`).
  - SW: wdata = d, wstrb = 1111.
- Load formatting:
  - Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
  - B/H are sign-extended; BU/HU are zero-extended; W passes through.
- `mem_read_data` holds its value until the next load completes. Stores do not modify it.
- `dbus_gnt` outside REQ and `dbus_rvalid` outside WAIT are ignored.

## Timing
- Reset (`rst_n`=0, asynchronous, including mid-transaction):
  - State → IDLE.
  - `dbus_req`=0, `dbus_we`=0, `dbus_addr`=0, `dbus_wdata`=0, `dbus_wstrb`=0, `mem_read_data`=0.
  - A pending bus transaction is abandoned.
- Latency, counting the cycle the access appears as cycle 0:
  - Store, gnt in the first REQ cycle: IDLE(c0), REQ(c1), DONE(c2). `mem_busy` is high in c0–c1 (2 stall cycles).
  - Load, gnt in c1 and rvalid in c2: IDLE, REQ, WAIT, DONE(c3). `mem_read_data` is valid from c3, so the MEM/WB register captures it at the end of c3.
- Each cycle of gnt or rvalid delay adds one stall cycle. There is no timeout.
- `dbus_rvalid` may not arrive in the same cycle as `dbus_gnt`; the unit does not sample it in REQ.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, gnt after 2 cycles:
  - `dbus_req` is held 2 cycles with addr 0x100, wstrb 1111, wdata 0xDEADBEEF.
  - `mem_busy` is high 3 cycles, then one DONE cycle.
- SB to 0x103 with data 0x000000A5:
  - wdata 0xA5A5A5A5, wstrb 1000, addr 0x100.
- LB from 0x102 with rdata 0x12F43456:
  - `mem_read_data` = 0xFFFFFFF4.
  - LBU from the same address gives 0x000000F4.
  - LH from 0x102 gives 0x000012F4.
- LW from 0x101, then LH from 0x003, then `funct3`=011:
  - `mem_access_fault`=1, `mem_busy`=0 and `dbus_req` stays 0 in each case.
- Load outstanding in WAIT, then `rst_n` pulsed low for 1 cycle:
  - All outputs return to 0 immediately.
  - A later `dbus_rvalid` with 0xCAFEF00D leaves `mem_read_data`=0.
- Back-to-back LW then SW, with gnt and rvalid delays of 0:
  - Two distinct bus requests are issued, with no duplicate request in the DONE cycle.
